// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: constants shared by the ALU/CDB unit and the reservation-station queues.
//   alu_op_e        : 1-bit opcode, OP_ADD = 0, OP_SUB = 1 (A - B)
//   LABEL_NONE      : reserved tag meaning "no producer"
//   LABEL_Q0..Q2    : tags identifying the reservation-station queues
package tomasulo_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } alu_op_e;

   localparam int unsigned LABEL_NONE = 0;
   localparam int unsigned LABEL_Q0   = 1;
   localparam int unsigned LABEL_Q1   = 2;
   localparam int unsigned LABEL_Q2   = 3;

endpackage

// File: rtl/cdb_result_fifo.sv
// cdb_result_fifo: DEPTH-entry circular FIFO holding finished results awaiting the CDB.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   push, push_data  : write an entry (legal when full only if pop is asserted the same cycle)
//   pop              : remove the head entry
//   head             : current head entry (valid when !empty)
//   empty, full      : occupancy flags, decoded from registered count
module cdb_result_fifo
   import tomasulo_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 37
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push, do_pop;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is then legal.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr_q] <= push_data;
            wr_ptr_q      <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/alu_cdb_unit.sv
// alu_cdb_unit: fixed-latency ADD/SUB execution unit that buffers results and broadcasts them on
// the common data bus.
// Ports:
//   clk, RST                    : clock, asynchronous active-high reset
//   issueValid, requireAC       : issue handshake with the reservation-station queue
//   issueOp/A/B/Label           : operation (0 ADD, 1 SUB), operands, destination tag
//   cdbReq, cdbGrant            : request/grant with the external CDB arbiter
//   BCEN, BClabel, BCdata       : broadcast; label/data are zero when BCEN is low
//   BCovf                       : only with ALU_OVF_FLAG_EN defined; signed overflow of the result
// Configuration macro: ALU_OVF_FLAG_EN adds the BCovf port and one overflow bit per buffer entry.
module alu_cdb_unit
   import tomasulo_pkg::*;
#(
   parameter int unsigned LAT       = 2,
   parameter int unsigned RES_DEPTH = 4,
   parameter int unsigned W         = 32,
   parameter int unsigned LW        = 5
) (
   input  logic          clk,
   input  logic          RST,
   input  logic          issueValid,
   output logic          requireAC,
   input  logic          issueOp,
   input  logic [W-1:0]  issueA,
   input  logic [W-1:0]  issueB,
   input  logic [LW-1:0] issueLabel,
   output logic          cdbReq,
   input  logic          cdbGrant,
   output logic          BCEN,
   output logic [LW-1:0] BClabel,
   output logic [W-1:0]  BCdata
`ifdef ALU_OVF_FLAG_EN
   ,
   output logic          BCovf
`endif
);

`ifdef ALU_OVF_FLAG_EN
   localparam int unsigned OW = 1;
`else
   localparam int unsigned OW = 0;
`endif
   localparam int unsigned EW = LW + W + OW;
   localparam int unsigned CW = $clog2(RES_DEPTH + 1);

   logic            accept, push, drop;
   logic [W-1:0]    alu_res;
   logic [LAT-1:0]  st_vld_q;
   logic [LW-1:0]   st_lbl_q [LAT];
   logic [W-1:0]    st_res_q [LAT];
   logic [CW-1:0]   cnt_q;
   logic [EW-1:0]   push_data, head;
   logic            fifo_empty;
   logic            unused_fifo_full;

   assign accept = issueValid && requireAC;

   always_comb begin
      alu_res = issueA + issueB;
      if (issueOp == OP_SUB) alu_res = issueA - issueB;
   end

`ifdef ALU_OVF_FLAG_EN
   logic           alu_ovf;
   logic [LAT-1:0] st_ovf_q;

   // Overflow: operand signs (B inverted for SUB) agree but the result sign differs from A.
   always_comb begin
      alu_ovf = (issueA[W-1] == issueB[W-1]) && (alu_res[W-1] != issueA[W-1]);
      if (issueOp == OP_SUB) begin
         alu_ovf = (issueA[W-1] != issueB[W-1]) && (alu_res[W-1] != issueA[W-1]);
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) st_ovf_q <= '0;
      else begin
         st_ovf_q[0] <= alu_ovf;
         for (int i = 1; i < int'(LAT); i++) st_ovf_q[i] <= st_ovf_q[i-1];
      end
   end

   assign push_data = {st_lbl_q[LAT-1], st_res_q[LAT-1], st_ovf_q[LAT-1]};
   assign BCovf     = BCEN ? head[0] : 1'b0;
`else
   assign push_data = {st_lbl_q[LAT-1], st_res_q[LAT-1]};
`endif

   // Valid-tagged shift register; result computed at issue and carried LAT stages.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         st_vld_q <= '0;
         for (int i = 0; i < int'(LAT); i++) begin
            st_lbl_q[i] <= '0;
            st_res_q[i] <= '0;
         end
      end else begin
         st_vld_q[0] <= accept;
         st_lbl_q[0] <= issueLabel;
         st_res_q[0] <= alu_res;
         for (int i = 1; i < int'(LAT); i++) begin
            st_vld_q[i] <= st_vld_q[i-1];
            st_lbl_q[i] <= st_lbl_q[i-1];
            st_res_q[i] <= st_res_q[i-1];
         end
      end
   end

   // Label-0 ops never reach the buffer; their credit is returned at the would-be push edge.
   assign push = st_vld_q[LAT-1] && (st_lbl_q[LAT-1] != LW'(LABEL_NONE));
   assign drop = st_vld_q[LAT-1] && (st_lbl_q[LAT-1] == LW'(LABEL_NONE));

   cdb_result_fifo #(
      .DEPTH (RES_DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk       (clk),
      .rst       (RST),
      .push      (push),
      .push_data (push_data),
      .pop       (BCEN),
      .head      (head),
      .empty     (fifo_empty),
      .full      (unused_fifo_full)
   );

   assign cdbReq  = !fifo_empty;
   assign BCEN    = cdbReq && cdbGrant;
   assign BClabel = BCEN ? head[EW-1 -: LW] : '0;
   assign BCdata  = BCEN ? head[OW +: W] : '0;

   // A pop this cycle frees a credit, so accepting at full count is still safe.
   assign requireAC = (cnt_q < CW'(RES_DEPTH)) || BCEN;

   always_ff @(posedge clk or posedge RST) begin
      if (RST) cnt_q <= '0;
      else     cnt_q <= cnt_q + CW'(accept) - CW'(BCEN) - CW'(drop);
   end

endmodule
